sar4_control: RTL

SAR4_CONTROL -- requirements
Module: sar4_control

---
 rtl/sar4_control.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/sar4_control.sv
// -----------------------------------------------------------------------------
// sar4_control
//
// Successive-approximation ADC sequencer. A rising edge on `start` while idle
// closes the track/hold switch for SAMPLE_CYCLES cycles. The capacitive DAC
// then walks from the MSB down to the LSB. Each trial bit is set, allowed to
// settle for SETTLE_CYCLES cycles, and then kept or cleared according to the
// comparator at the closing edge of a one-cycle decision slot. When the LSB
// has been decided, the final code is latched into `result` and `done` pulses
// for a single cycle.
//
// Conversion latency, counted from the edge that accepts `start` to the edge
// that enters the done cycle, is:
//     SAMPLE_CYCLES + N_BITS * (SETTLE_CYCLES + 1)
//
// Ports
//   clk     in   1       clock; all state changes on its rising edge
//   rst_n   in   1       asynchronous active-low reset
//   start   in   1       conversion request; only a 0->1 transition seen
//                        while idle starts a conversion
//   comp    in   1       comparator: 1 = Vin >= Vdac (keep trial bit)
//   sample  out  1       track/hold switch; 1 = track
//   dac     out  N_BITS  DAC code currently under trial
//   busy    out  1       high from the sample phase through the done cycle
//   done    out  1       one-cycle end-of-conversion pulse
//   result  out  N_BITS  last completed code; held until the next done
// -----------------------------------------------------------------------------
module sar4_control #(
    parameter int N_BITS        = 4,  // 2..8
    parameter int SAMPLE_CYCLES = 2,  // 1..15
    parameter int SETTLE_CYCLES = 1   // 1..15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              comp,
    output logic              sample,
    output logic [N_BITS-1:0] dac,
    output logic              busy,
    output logic              done,
    output logic [N_BITS-1:0] result
);

    localparam int IDX_W = $clog2(N_BITS);
    localparam int CNT_W = 4;

    localparam logic [IDX_W-1:0]  IDX_MSB     = IDX_W'(N_BITS - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_BITS-1:0] LSB_ONE     = N_BITS'(1);
    localparam logic [N_BITS-1:0] MSB_ONE     = LSB_ONE << (N_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_SETTLE,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t              state_q,  state_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [IDX_W-1:0]    idx_q,    idx_d;
    logic                sample_q, sample_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic [N_BITS-1:0]   dac_q,    dac_d;
    logic [N_BITS-1:0]   result_q, result_d;

    // Previous-cycle copy of start, used for 0->1 edge detection.
    logic                start_prev_q;
    logic                start_rise;

    // One-hot mask selecting the bit currently under trial.
    logic [N_BITS-1:0]   trial_mask;

    assign start_rise = start & ~start_prev_q;
    assign trial_mask = LSB_ONE << idx_q;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= IDX_MSB;
            sample_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dac_q        <= '0;
            result_q     <= '0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            sample_q     <= sample_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            dac_q        <= dac_d;
            result_q     <= result_d;
            start_prev_q <= start;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    logic [N_BITS-1:0] kept;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sample_d = sample_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dac_d    = dac_q;
        result_d = result_q;
        // The trial bit survives only if the input is at least the DAC level.
        // Bits above the trial bit are never touched, so decided bits stay put.
        kept     = comp ? dac_q : (dac_q & ~trial_mask);

        unique case (state_q)
            S_IDLE: begin
                sample_d = 1'b0;
                busy_d   = 1'b0;
                dac_d    = '0;
                if (start_rise) begin
                    state_d  = S_SAMPLE;
                    sample_d = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    idx_d    = IDX_MSB;
                end
            end

            S_SAMPLE: begin
                if (cnt_q == SAMPLE_LAST) begin
                    // Open the switch and present the MSB trial in the same edge.
                    state_d  = S_SETTLE;
                    sample_d = 1'b0;
                    dac_d    = MSB_ONE;
                    idx_d    = IDX_MSB;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_DECIDE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DECIDE: begin
                if (idx_q == '0) begin
                    state_d  = S_DONE;
                    dac_d    = kept;
                    result_d = kept;
                    done_d   = 1'b1;
                end else begin
                    // Resolve this bit and raise the next lower trial bit at once,
                    // so each bit costs exactly SETTLE_CYCLES + 1 edges.
                    state_d = S_SETTLE;
                    dac_d   = kept | (trial_mask >> 1);
                    idx_d   = idx_q - IDX_W'(1);
                    cnt_d   = '0;
                end
            end

            S_DONE: begin
                state_d  = S_IDLE;
                busy_d   = 1'b0;
                sample_d = 1'b0;
                dac_d    = '0;
                idx_d    = IDX_MSB;
            end

            default: begin
                state_d  = S_IDLE;
                sample_d = 1'b0;
                busy_d   = 1'b0;
                dac_d    = '0;
                cnt_d    = '0;
                idx_d    = IDX_MSB;
            end
        endcase
    end

    assign sample = sample_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign dac    = dac_q;
    assign result = result_q;

endmodule
